// File: rtl/ga_pkg.sv
// Shared types and helpers for the GA crossover stage.
package ga_pkg;

  typedef enum logic [1:0] {IDLE, CALC, OUT} xover_state_e;

  // Rate compares are done on this scale (1/256 units).
  localparam int RATE_SCALE = 256;

  // Cut point 1 + ((sel * (width-1)) >> 8). The product is at most
  // 255*(width-1), which fits the 8+clog2(width) bit unsigned product.
  function automatic int unsigned cut_point(input logic [7:0] sel,
                                            input int unsigned width);
    int unsigned prod;
    prod = 32'(sel) * (width - 1);
    return 1 + (prod >> 8);
  endfunction

  // One mask bit: set when lo <= k < hi. A single cut point pt is the
  // range lo=0, hi=pt.
  function automatic logic mask_bit(input int unsigned k,
                                    input int unsigned lo,
                                    input int unsigned hi);
    return (k >= lo) && (k < hi);
  endfunction

endpackage

// File: rtl/lfsr_rng.sv
// Free-running 32-bit Galois LFSR (x^32+x^22+x^2+x+1), seeded under reset.
module lfsr_rng (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] seed,
  output logic [31:0] rnd
);

  logic [31:0] rnd_q, rnd_d;

  // Next state: shift right, fold taps back in when the LSB is set.
  always_comb begin
    rnd_d = {1'b0, rnd_q[31:1]} ^ (rnd_q[0] ? 32'h8020_0003 : 32'h0);
  end

  // A zero seed would lock the LFSR, so it is replaced by 1.
  always_ff @(posedge clk) begin
    if (reset) rnd_q <= (seed == 32'h0) ? 32'h1 : seed;
    else       rnd_q <= rnd_d;
  end

  assign rnd = rnd_q;

endmodule

// File: rtl/xover_mask_gen.sv
// Crossover mask generator: single-point mask from a, or a two-point
// range mask from a and b when two_pt_en is set and the points differ.
module xover_mask_gen
  import ga_pkg::*;
#(
  parameter int CHROM_WIDTH = 8
) (
  input  logic [7:0]             a,
  input  logic [7:0]             b,
  input  logic                   two_pt_en,
  output logic [CHROM_WIDTH-1:0] mask
);

  int unsigned pt, pb, lo, hi;

  // Derive the bit range to swap, then expand it to a mask.
  always_comb begin
    pt = cut_point(a, CHROM_WIDTH);
    pb = cut_point(b, CHROM_WIDTH);
    if (two_pt_en && (pt != pb)) begin
      lo = (pt < pb) ? pt : pb;
      hi = (pt < pb) ? pb : pt;
    end else begin
      lo = 0;
      hi = pt;
    end
    for (int k = 0; k < CHROM_WIDTH; k++) mask[k] = mask_bit(k, lo, hi);
  end

endmodule

// File: rtl/crossover_unit.sv
// GA crossover stage: accept a parent pair, decide by XOVER_RATE whether
// to recombine, cut at a random point, present children with valid/ready.
// Define TWO_POINT_XOVER_EN for two-point crossover using rnd[23:16].
module crossover_unit
  import ga_pkg::*;
#(
  parameter int CHROM_WIDTH = 8,
  parameter int XOVER_RATE  = 230
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            seed,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CHROM_WIDTH-1:0] parent1,
  input  logic [CHROM_WIDTH-1:0] parent2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CHROM_WIDTH-1:0] orig_child1,
  output logic [CHROM_WIDTH-1:0] orig_child2,
  output logic [15:0]            xover_count
);

  localparam int RATE_W = $clog2(RATE_SCALE) + 1;

  logic [31:0]            rnd;
  xover_state_e           state_q, state_d;
  logic [CHROM_WIDTH-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [CHROM_WIDTH-1:0] child1_q, child1_d, child2_q, child2_d;
  logic [7:0]             r_q, r_d, a_q, a_d;
  logic                   out_valid_q, out_valid_d;
  logic                   xover_q, xover_d;
  logic [15:0]            xover_count_q, xover_count_d;
  logic [CHROM_WIDTH-1:0] mask;
  logic [7:0]             b_sel;
  logic                   two_pt;
  logic                   accept, recomb;

  lfsr_rng u_rng (
    .clk   (clk),
    .reset (reset),
    .seed  (seed),
    .rnd   (rnd)
  );

`ifdef TWO_POINT_XOVER_EN
  logic [7:0] b_q;
  logic       unused_rnd;
  assign unused_rnd = ^rnd[31:24];
  assign b_sel      = b_q;
  assign two_pt     = 1'b1;

  // Second point byte captured alongside the other accept-time values.
  always_ff @(posedge clk) begin
    if (reset)       b_q <= 8'h00;
    else if (accept) b_q <= rnd[23:16];
  end
`else
  logic unused_rnd;
  assign unused_rnd = ^rnd[31:16];
  assign b_sel      = 8'h00;
  assign two_pt     = 1'b0;
`endif

  xover_mask_gen #(.CHROM_WIDTH(CHROM_WIDTH)) u_mask (
    .a         (a_q),
    .b         (b_sel),
    .two_pt_en (two_pt),
    .mask      (mask)
  );

  // IDLE always ready; OUT can take a new pair in its delivery cycle.
  assign in_ready = (state_q == IDLE) || ((state_q == OUT) && out_ready);
  assign accept   = in_valid && in_ready;
  assign recomb   = {1'b0, r_q} < RATE_W'(XOVER_RATE);

  // FSM next state, capture of parents/random bytes, child computation.
  always_comb begin
    state_d       = state_q;
    p1_d          = p1_q;
    p2_d          = p2_q;
    r_d           = r_q;
    a_d           = a_q;
    child1_d      = child1_q;
    child2_d      = child2_q;
    out_valid_d   = out_valid_q;
    xover_d       = xover_q;
    xover_count_d = xover_count_q;
    unique case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: begin
        child1_d    = recomb ? ((p1_q & ~mask) | (p2_q & mask)) : p1_q;
        child2_d    = recomb ? ((p2_q & ~mask) | (p1_q & mask)) : p2_q;
        xover_d     = recomb;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        if (xover_q && (xover_count_q != 16'hFFFF))
          xover_count_d = xover_count_q + 16'd1;
        state_d = in_valid ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      p1_d = parent1;
      p2_d = parent2;
      r_d  = rnd[7:0];
      a_d  = rnd[15:8];
    end
  end

  // State registers; reset drops any in-flight pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      p1_q          <= '0;
      p2_q          <= '0;
      r_q           <= 8'h00;
      a_q           <= 8'h00;
      child1_q      <= '0;
      child2_q      <= '0;
      out_valid_q   <= 1'b0;
      xover_q       <= 1'b0;
      xover_count_q <= 16'h0;
    end else begin
      state_q       <= state_d;
      p1_q          <= p1_d;
      p2_q          <= p2_d;
      r_q           <= r_d;
      a_q           <= a_d;
      child1_q      <= child1_d;
      child2_q      <= child2_d;
      out_valid_q   <= out_valid_d;
      xover_q       <= xover_d;
      xover_count_q <= xover_count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign orig_child1 = child1_q;
  assign orig_child2 = child2_q;
  assign xover_count = xover_count_q;

endmodule

// File: tb/tb_crossover_unit.sv
// Scoreboard bench: a rate-0 and a rate-256 unit share stimulus; a monitor
// checks each delivered pair against the crossover rules.
module tb_crossover_unit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, in_valid, out_ready;
  logic [31:0]  seed;
  logic [W-1:0] parent1, parent2;
  logic         in_ready0, in_ready1, out_valid0, out_valid1;
  logic [W-1:0] c1_0, c2_0, c1_1, c2_1;
  logic [15:0]  cnt0, cnt1;
  logic [7:0]   mg_a, mg_b;
  logic         mg_en;
  logic [W-1:0] mg_mask;

  always #5 clk = ~clk;

  crossover_unit #(.CHROM_WIDTH(W), .XOVER_RATE(0)) u_dut0 (
    .clk(clk), .reset(reset), .seed(seed), .in_valid(in_valid),
    .in_ready(in_ready0), .parent1(parent1), .parent2(parent2),
    .out_valid(out_valid0), .out_ready(out_ready), .orig_child1(c1_0),
    .orig_child2(c2_0), .xover_count(cnt0));

  crossover_unit #(.CHROM_WIDTH(W), .XOVER_RATE(256)) u_dut1 (
    .clk(clk), .reset(reset), .seed(seed), .in_valid(in_valid),
    .in_ready(in_ready1), .parent1(parent1), .parent2(parent2),
    .out_valid(out_valid1), .out_ready(out_ready), .orig_child1(c1_1),
    .orig_child2(c2_1), .xover_count(cnt1));

  xover_mask_gen #(.CHROM_WIDTH(W)) u_mg (
    .a(mg_a), .b(mg_b), .two_pt_en(mg_en), .mask(mg_mask));

  typedef struct packed { logic [W-1:0] p1; logic [W-1:0] p2; } pair_t;
  pair_t       q0[$], q1[$];
  logic [15:0] exp_cnt0, exp_cnt1;
  int          checks = 0, failures = 0;
  int          kseen[W];
  bit          bp_rand = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Smallest k in 1..W-1 for which the children are a single-point swap
  // of the low k bits; -1 when no such cut exists.
  function automatic int find_cut(input logic [W-1:0] p1, input logic [W-1:0] p2,
                                  input logic [W-1:0] c1, input logic [W-1:0] c2);
    logic [W-1:0] m;
    for (int k = 1; k < W; k++) begin
      m = '0;
      for (int j = 0; j < k; j++) m[j] = 1'b1;
      if (c1 == ((p1 & ~m) | (p2 & m)) && c2 == ((p2 & ~m) | (p1 & m))) return k;
    end
    return -1;
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    pair_t e;
    int    k;
    if (reset) begin
      q0.delete(); q1.delete();
      exp_cnt0 = 16'h0; exp_cnt1 = 16'h0;
    end else begin
      check("count0", 64'(cnt0), 64'(exp_cnt0));
      check("count1", 64'(cnt1), 64'(exp_cnt1));
      if (out_valid0 && out_ready) begin
        if (q0.size() == 0) check("dut0_unexpected_out", 64'(1), 64'(0));
        else begin
          e = q0.pop_front();
          check("pass_child1", 64'(c1_0), 64'(e.p1));
          check("pass_child2", 64'(c2_0), 64'(e.p2));
        end
      end
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) check("dut1_unexpected_out", 64'(1), 64'(0));
        else begin
          e = q1.pop_front();
          k = find_cut(e.p1, e.p2, c1_1, c2_1);
          check("xover_cut_valid", 64'(k > 0), 64'(1));
          check("xover_invariant", 64'(c1_1 ^ c2_1), 64'(e.p1 ^ e.p2));
          if (k > 0 && (e.p1 ^ e.p2) == {W{1'b1}}) kseen[k]++;
          exp_cnt1 = (exp_cnt1 == 16'hFFFF) ? 16'hFFFF : exp_cnt1 + 16'd1;
        end
      end
    end
  end

  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    pair_t e;
    e.p1 = a; e.p2 = b;
    q0.push_back(e); q1.push_back(e);
  endtask

  // Present a pair and hold it until the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; parent1 = a; parent2 = b;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (in_ready0) begin push_pair(a, b); ok = 1; break; end
      @(posedge clk); #1;
      if (bp_rand) out_ready = ($urandom_range(0, 2) != 0);
    end
    if (!ok) check("accept_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (bp_rand) out_ready = ($urandom_range(0, 2) != 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] h1, h2, x;
    int distinct;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; seed = 32'h1ACE_B00C;
    parent1 = '0; parent2 = '0;
    foreach (kseen[i]) kseen[i] = 0;

    // Mask generator in isolation.
    mg_en = 0; mg_b = 8'h00;
    mg_a = 8'd0;   #1 check("mask_a0",   64'(mg_mask), 64'(8'h01));
    mg_a = 8'd255; #1 check("mask_a255", 64'(mg_mask), 64'(8'h7F));
    mg_a = 8'd128; #1 check("mask_a128", 64'(mg_mask), 64'(8'h0F));
    mg_en = 1;
    mg_a = 8'd0;   mg_b = 8'd255; #1 check("mask2_0_255",   64'(mg_mask), 64'(8'h7E));
    mg_a = 8'd255; mg_b = 8'd0;   #1 check("mask2_255_0",   64'(mg_mask), 64'(8'h7E));
    mg_a = 8'd128; mg_b = 8'd128; #1 check("mask2_equal",   64'(mg_mask), 64'(8'h0F));
    mg_a = 8'd0;   mg_b = 8'd128; #1 check("mask2_0_128",   64'(mg_mask), 64'(8'h0E));

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready1),  64'(1));
    check("rst_out_valid", 64'(out_valid1), 64'(0));
    check("rst_child1",    64'(c1_1),       64'(0));
    check("rst_child2",    64'(c2_1),       64'(0));
    check("rst_count",     64'(cnt1),       64'(0));
    @(posedge clk); #1 reset = 1'b0;

    // Pass-through pair with latency check.
    @(posedge clk); #1;
    in_valid = 1'b1; parent1 = 8'hF0; parent2 = 8'h0F;
    @(negedge clk);
    check("first_in_ready", 64'(in_ready0), 64'(1));
    push_pair(8'hF0, 8'h0F);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); check("lat_calc_low", 64'(out_valid0), 64'(0));
    @(negedge clk); check("lat_out_high", 64'(out_valid0), 64'(1));
    check("pt_child1", 64'(c1_0), 64'(8'hF0));
    check("pt_child2", 64'(c2_0), 64'(8'h0F));

    // Always-recombine on complementary parents.
    for (int i = 0; i < 50; i++) send(8'hFF, 8'h00);
    repeat (4) @(negedge clk);
    check("count_after_50", 64'(cnt1), 64'(51));
    check("count0_zero",    64'(cnt0), 64'(0));

    // Random parents with random backpressure.
    bp_rand = 1;
    for (int i = 0; i < 60; i++) begin
      h1 = W'($urandom);
      h2 = (i % 2 == 0) ? ~h1 : W'($urandom);
      send(h1, h2);
    end
    bp_rand = 0; out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("drain_q0", 64'(q0.size()), 64'(0));
    check("drain_q1", 64'(q1.size()), 64'(0));

    // Backpressure hold, then same-cycle deliver and accept.
    @(posedge clk); #1 out_ready = 1'b0;
    send(8'hA5, 8'h3C);
    repeat (2) @(negedge clk);
    h1 = c1_1; h2 = c2_1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid",    64'(out_valid1), 64'(1));
      check("bp_child1",   64'(c1_1),       64'(h1));
      check("bp_child2",   64'(c2_1),       64'(h2));
      check("bp_in_ready", 64'(in_ready1),  64'(0));
    end
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b1; parent1 = 8'h96; parent2 = 8'h69;
    @(negedge clk);
    check("b2b_in_ready", 64'(in_ready1), 64'(1));
    push_pair(8'h96, 8'h69);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); check("b2b_calc_low", 64'(out_valid1), 64'(0));
    @(negedge clk); check("b2b_out_high", 64'(out_valid1), 64'(1));
    repeat (2) @(negedge clk);

    // Reset during CALC.
    x = 8'hC3;
    @(posedge clk); #1;
    in_valid = 1'b1; parent1 = x; parent2 = ~x;
    @(negedge clk); push_pair(x, ~x);
    @(posedge clk); #1 in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid",    64'(out_valid1), 64'(0));
    check("mid_rst_child1",   64'(c1_1),       64'(0));
    check("mid_rst_child2",   64'(c2_1),       64'(0));
    check("mid_rst_count",    64'(cnt1),       64'(0));
    check("mid_rst_in_ready", 64'(in_ready1),  64'(1));
    repeat (6) begin
      @(negedge clk);
      check("no_stale_out", 64'(out_valid1 | out_valid0), 64'(0));
    end

    // Saturation.
    @(posedge clk); #2;
    force u_dut1.xover_count_q = 16'hFFFE;
    exp_cnt1 = 16'hFFFE;
    #1 release u_dut1.xover_count_q;
    for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom));
    repeat (4) @(negedge clk);
    check("sat_count", 64'(cnt1), 64'(16'hFFFF));

    // Cut points should spread over the legal range.
    distinct = 0;
    for (int k = 1; k < W; k++) if (kseen[k] > 0) distinct++;
    check("cut_spread", 64'(distinct >= 5), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
